// File: rtl/mem_responder_pkg.sv
// Shared encodings and types for the memory responder and its lane helper.
// Combinational definitions only; no latency, no backpressure.
package mem_responder_pkg;

    localparam logic SIZE_WORD = 1'b0;
    localparam logic SIZE_BYTE = 1'b1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WAIT   = 3'd1;
    localparam logic [2:0] ST_RMW_RD = 3'd2;
    localparam logic [2:0] ST_RMW_WR = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    typedef struct packed {
        logic        we;
        logic        size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } acc_t;

    function automatic logic [31:0] sext_byte(input logic [7:0] b);
        return {{24{b[7]}}, b};
    endfunction

endpackage

// File: rtl/mem_responder_bac_lane.sv
// Byte-lane helper: sign-extended lane extract for loads, lane merge for stores.
// Purely combinational; no backpressure.
module bac_lane
    import mem_responder_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [7:0]  wbyte,
    output logic [31:0] load_ext,
    output logic [31:0] merged
);

    always_comb begin
        merged                     = word;
        merged[{lane, 3'b000} +: 8] = wbyte;
        load_ext                   = sext_byte(word[{lane, 3'b000} +: 8]);
    end

endmodule

// File: rtl/mem_responder.sv
// Word/byte memory responder with programmable wait latency and read-modify-write byte stores.
// Latency 1+LATENCY cycles (byte store 3+LATENCY, misaligned word 1); busy blocks new requests.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic        size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        err
);

    localparam int         IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    logic [2:0]       state, state_nxt;
    logic [3:0]       cnt;
    acc_t             acc_q, cur;
    logic [31:0]      mem [DEPTH_WORDS];
    logic [31:0]      rmw_word, mem_word, lane_word, load_ext, merged;
    logic [IDX_W-1:0] idx;
    logic             misalign, byte_wr;
    logic             unused_hi;

    // In IDLE the live inputs describe the access; afterwards the latched copy does.
    always_comb begin
        cur = acc_q;
        if (state == ST_IDLE) begin
            cur = '{we: we, size: size, addr: addr, wdata: wdata};
        end
    end

    assign idx       = cur.addr[2 +: IDX_W];
    assign unused_hi = ^cur.addr[31:IDX_W+2];
    assign mem_word  = mem[idx];
    assign misalign  = (cur.size == SIZE_WORD) && (cur.addr[1:0] != 2'b00);
    assign byte_wr   = cur.we && (cur.size == SIZE_BYTE);
    assign lane_word = (state == ST_RMW_WR) ? rmw_word : mem_word;
    assign busy      = (state != ST_IDLE);
    assign ready     = (state == ST_DONE);

    bac_lane u_lane (
        .word     (lane_word),
        .lane     (cur.addr[1:0]),
        .wbyte    (cur.wdata[7:0]),
        .load_ext (load_ext),
        .merged   (merged)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    if (misalign)          state_nxt = ST_DONE;
                    else if (LATENCY == 0) state_nxt = byte_wr ? ST_RMW_RD : ST_DONE;
                    else                   state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt == 4'd0) state_nxt = byte_wr ? ST_RMW_RD : ST_DONE;
            end
            ST_RMW_RD: state_nxt = ST_RMW_WR;
            ST_RMW_WR: state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= 4'd0;
            acc_q    <= '0;
            rmw_word <= 32'd0;
            rdata    <= 32'd0;
            err      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && req) begin
                acc_q <= cur;
                cnt   <= CNT_INIT;
            end
            if (state == ST_WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
            if (state == ST_RMW_RD) rmw_word <= mem_word;
            // Result registers are loaded on the edge that enters DONE.
            if (state_nxt == ST_DONE && state != ST_DONE) begin
                if (misalign) begin
                    rdata <= 32'd0;
                    err   <= 1'b1;
                end else begin
                    err <= 1'b0;
                    if (!cur.we) rdata <= (cur.size == SIZE_BYTE) ? load_ext : mem_word;
                end
            end
        end
    end

    // Storage is never reset; an access interrupted by reset commits nothing.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == ST_DONE && cur.we && cur.size == SIZE_WORD && !misalign)
                mem[idx] <= cur.wdata;
            if (state == ST_RMW_WR)
                mem[idx] <= merged;
        end
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning internal storage size in 32-bit words (power of two).
REQ-002 SHALL have parameter LATENCY, default 2, meaning wait cycles before each access completes (0..15).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port req, input, 1, access request from the controller, sampled only in IDLE.
REQ-006 SHALL have port we, input, 1, 1 = write, 0 = read, sampled with req.
REQ-007 SHALL have port size, input, 1, 0 = word, 1 = byte, using the controller's word/byte access encoding.
REQ-008 SHALL have port addr, input, 32, byte address, sampled with req.
REQ-009 SHALL have port wdata, input, 32, store data (byte stores use bits 7:0), sampled with req.
REQ-010 SHALL have port rdata, output, 32, registered load data, valid when ready is high and held until the next completion.
REQ-011 SHALL have port ready, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-013 SHALL have port err, output, 1, misalignment flag, valid with ready.

Function
REQ-014 SHALL implement states IDLE, WAIT, RMW_RD, RMW_WR and DONE.
REQ-015 SHALL, in IDLE with req=1, latch we/size/addr/wdata and go to WAIT, or go directly to DONE when LATENCY=0 and the access is not a byte write.
REQ-016 SHALL stay in WAIT for exactly LATENCY cycles using a down-counter loaded with LATENCY-1.
REQ-017 SHALL, after WAIT, go to RMW_RD for a byte write and to DONE for all other accesses.
REQ-018 SHALL, in RMW_RD, latch the addressed word; in RMW_WR, write back that word with lane addr[1:0] replaced by wdata[7:0] (little-endian); then go to DONE.
REQ-019 SHALL, in DONE, assert ready for one cycle and return to IDLE; a req in the DONE cycle is ignored.
REQ-020 SHALL give a word read or write with req sampled at edge t a ready high in cycle t+1+LATENCY; a byte read the same; a byte write t+3+LATENCY.
REQ-021 SHALL commit a word write to storage on the edge leaving DONE, and a byte write on the edge leaving RMW_WR.
REQ-022 SHALL return mem[index] on a word read, and on a byte read the lane addr[1:0] sign-extended to 32 bits.
REQ-023 SHALL compute index as addr[2 +: log2(DEPTH_WORDS)] and ignore higher address bits, so addresses wrap modulo DEPTH_WORDS*4.
REQ-024 SHALL treat a word access with addr[1:0]!=0 as an error: go IDLE->DONE in 1 cycle regardless of LATENCY, perform no write, and drive rdata=0 and err=1 with ready.
REQ-025 SHALL hold err at 0 on every non-error completion, and SHALL leave rdata unchanged on writes.
REQ-026 SHALL ignore req, we, size, addr and wdata while busy=1, since the controller holds the request until ready.

Reset
REQ-027 SHALL, on reset, force state IDLE and rdata=0, ready=0, busy=0, err=0, with the counter cleared.
REQ-028 SHALL, on reset mid-operation, abort the access without committing any pending write, and SHALL not clear storage contents.
REQ-029 SHALL give reset priority over req in the same cycle.

Structure
REQ-030 SHALL take the size encodings (word/byte) and state encodings from the shared macro header, not local literals.
REQ-031 SHALL place lane extract/sign-extend and lane merge in one combinational sub-module, bac_lane.
REQ-032 SHALL hold storage in a single reg array inside mem_responder, with no storage initialisation beyond the bench's.

Verification
REQ-033 Word store then load, LATENCY=2: store 0xDEADBEEF at 0x10 -> ready at t+3; load 0x10 -> rdata=0xDEADBEEF at t+3, err=0.
REQ-034 Byte store then load: 0x000000AB to 0x13 over word 0x11223344 -> word reads 0xAB223344 (ready at t+5); lb 0x13 -> 0xFFFFFFAB; lb 0x10 -> 0x00000044.
REQ-035 Misaligned word load at 0x06 -> ready at t+1, err=1, rdata=0, and storage unchanged on a word read of 0x04.
REQ-036 Wrap: DEPTH_WORDS=1024, store 0x5 to 0x1000 -> a load of 0x0 returns 0x5.
REQ-037 Reset asserted during RMW_RD of a byte store -> busy=0 next cycle, no ready pulse, target word unchanged.
REQ-038 LATENCY=0: word load completes with ready in t+1; req pulses while busy produce no extra completions.
